// File: rtl/regfile_pkg.sv
// rtl/regfile_pkg.sv - shared defaults and index type for the register file scoreboard
// Purpose: defaults for data width, register count and the preloaded stack pointer register.
// Ports: none (package).
package regfile_pkg;

  localparam int RF_XLEN    = 32;
  localparam int RF_NREGS   = 32;
  localparam int RF_NRP     = 2;
  localparam int RF_SP_IDX  = 2;
  localparam int RF_SP_INIT = 512;
  localparam int RF_AW      = $clog2(RF_NREGS);

  typedef logic [RF_AW-1:0] reg_idx_t;

endpackage

// File: rtl/regfile_scoreboard_if.sv
// rtl/regfile_scoreboard_if.sv - read/write/issue bus of the register file scoreboard
// Purpose: bundles read ports, write port, reservation handshake and busy count.
// Ports: master drives rs, iss_valid, iss_rd, RuWr, rd, RuWrData;
//        slave drives ru, ru_busy, iss_ready, busy_cnt.
interface regfile_scoreboard_if
  import regfile_pkg::*;
#(
  parameter int XLEN  = RF_XLEN,
  parameter int NREGS = RF_NREGS,
  parameter int NRP   = RF_NRP
);
  localparam int AW = $clog2(NREGS);

  logic [NRP-1:0][AW-1:0]   rs;
  logic [NRP-1:0][XLEN-1:0] ru;
  logic [NRP-1:0]           ru_busy;
  logic                     iss_valid;
  logic [AW-1:0]            iss_rd;
  logic                     iss_ready;
  logic                     RuWr;
  logic [AW-1:0]            rd;
  logic [XLEN-1:0]          RuWrData;
  logic [AW:0]              busy_cnt;

  modport master (
    output rs, iss_valid, iss_rd, RuWr, rd, RuWrData,
    input  ru, ru_busy, iss_ready, busy_cnt
  );

  modport slave (
    input  rs, iss_valid, iss_rd, RuWr, rd, RuWrData,
    output ru, ru_busy, iss_ready, busy_cnt
  );

endinterface

// File: rtl/regfile_scoreboard_sb.sv
// rtl/regfile_scoreboard_sb.sv - busy-bit scoreboard with reservation handshake
// Purpose: tracks registers with a pending write, answers reservation requests
//          and keeps a running count of reserved registers.
// Ports: clk, rst (sync, active-high); rs/ru_busy read-port busy flags;
//        iss_valid/iss_rd/iss_ready reservation; wr_en/wr_addr write notify;
//        busy_cnt number of reserved registers.
module rf_scoreboard
  import regfile_pkg::*;
#(
  parameter int NREGS = RF_NREGS,
  parameter int NRP   = RF_NRP,
  localparam int AW   = $clog2(NREGS)
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic [NRP-1:0][AW-1:0] rs,
  output logic [NRP-1:0]         ru_busy,
  input  logic                   iss_valid,
  input  logic [AW-1:0]          iss_rd,
  output logic                   iss_ready,
  input  logic                   wr_en,
  input  logic [AW-1:0]          wr_addr,
  output logic [AW:0]            busy_cnt
);

  // Bit 0 is never set, so x0 reads as not busy and is always ready.
  logic [NREGS-1:0] busy;
  logic [NREGS-1:0] busy_next;
  logic             wr_hit;
  logic             reserve;
  logic             cnt_inc;
  logic             cnt_dec;

  assign wr_hit = wr_en && (wr_addr != '0);

  // A write landing this cycle frees its register early, so a reader or an
  // issuer targeting it already sees it as free.
  always_comb begin
    for (int p = 0; p < NRP; p++) begin
      ru_busy[p] = busy[rs[p]] && !(wr_en && (wr_addr == rs[p]));
    end
  end

  assign iss_ready = !busy[iss_rd] || (wr_en && (wr_addr == iss_rd));
  assign reserve   = iss_valid && iss_ready && (iss_rd != '0);

  // Clear first, then set: a same-cycle write and reservation of one
  // register leaves it reserved.
  always_comb begin
    busy_next = busy;
    if (wr_hit) begin
      busy_next[wr_addr] = 1'b0;
    end
    if (reserve) begin
      busy_next[iss_rd] = 1'b1;
    end
  end

  // Count changes only on real transitions of a busy bit. Reserving a busy
  // register is only possible when it is being written the same cycle; then
  // the bit stays set and neither term fires.
  assign cnt_inc = reserve && !busy[iss_rd];
  assign cnt_dec = wr_hit && busy[wr_addr] && !(reserve && (iss_rd == wr_addr));

  always_ff @(posedge clk) begin
    if (rst) begin
      busy     <= '0;
      busy_cnt <= '0;
    end else begin
      busy     <= busy_next;
      busy_cnt <= busy_cnt + {{AW{1'b0}}, cnt_inc} - {{AW{1'b0}}, cnt_dec};
    end
  end

endmodule

// File: rtl/regfile_scoreboard.sv
// rtl/regfile_scoreboard.sv - register file with write-first bypass and busy scoreboard
// Purpose: NREGS x XLEN register file, x0 hardwired to zero, register SP_IDX
//          preloaded at reset, plus a scoreboard of pending writes.
// Ports: clk, rst (sync, active-high); bus (slave) carrying read ports rs/ru/ru_busy,
//        write port RuWr/rd/RuWrData, reservation iss_valid/iss_rd/iss_ready, busy_cnt.
module regfile_scoreboard
  import regfile_pkg::*;
#(
  parameter int XLEN    = RF_XLEN,
  parameter int NREGS   = RF_NREGS,
  parameter int NRP     = RF_NRP,
  parameter int SP_IDX  = RF_SP_IDX,
  parameter int SP_INIT = RF_SP_INIT
) (
  input  logic                 clk,
  input  logic                 rst,
  regfile_scoreboard_if.slave  bus
);

  localparam int AW = $clog2(NREGS);

  logic [XLEN-1:0] regs [NREGS];

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < NREGS; i++) begin
        regs[i] <= (i == SP_IDX) ? XLEN'(SP_INIT) : '0;
      end
    end else if (bus.RuWr && (bus.rd != '0)) begin
      regs[bus.rd] <= bus.RuWrData;
    end
  end

  // Write-first bypass: a reader of the register being written this cycle
  // gets the incoming data rather than the stale stored value.
  always_comb begin
    for (int p = 0; p < NRP; p++) begin
      if (bus.rs[p] == '0) begin
        bus.ru[p] = '0;
      end else if (bus.RuWr && (bus.rd == bus.rs[p])) begin
        bus.ru[p] = bus.RuWrData;
      end else begin
        bus.ru[p] = regs[bus.rs[p]];
      end
    end
  end

  rf_scoreboard #(
    .NREGS (NREGS),
    .NRP   (NRP)
  ) u_sb (
    .clk       (clk),
    .rst       (rst),
    .rs        (bus.rs),
    .ru_busy   (bus.ru_busy),
    .iss_valid (bus.iss_valid),
    .iss_rd    (bus.iss_rd),
    .iss_ready (bus.iss_ready),
    .wr_en     (bus.RuWr),
    .wr_addr   (bus.rd),
    .busy_cnt  (bus.busy_cnt)
  );

endmodule

// File: tb/tb_regfile_scoreboard.sv
// tb/tb_regfile_scoreboard.sv - self-checking bench for regfile_scoreboard
module tb_regfile_scoreboard;

  localparam int XLEN  = 32;
  localparam int NREGS = 32;
  localparam int NRP   = 2;
  localparam int AW    = 5;

  logic clk;
  logic rst;
  bit   chk_en;
  int   n_tests;
  int   n_fail;

  logic [31:0] m_regs [NREGS];
  bit          m_busy [NREGS];

  regfile_scoreboard_if #(.XLEN(XLEN), .NREGS(NREGS), .NRP(NRP)) bus ();

  regfile_scoreboard #(
    .XLEN(XLEN), .NREGS(NREGS), .NRP(NRP), .SP_IDX(2), .SP_INIT(512)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Reference model: architectural state updated per the functional rules.
  always @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < NREGS; i++) begin
        m_regs[i] = 32'd0;
        m_busy[i] = 1'b0;
      end
      m_regs[2] = 32'd512;
    end else begin
      int  w;
      int  q;
      bit  rdy;
      w   = int'(bus.rd);
      q   = int'(bus.iss_rd);
      rdy = !m_busy[q] || (bus.RuWr && w == q);
      if (bus.RuWr && w != 0) begin
        m_regs[w] = bus.RuWrData;
        m_busy[w] = 1'b0;
      end
      if (bus.iss_valid && rdy && q != 0) m_busy[q] = 1'b1;
    end
  end

  // Compare process: every output checked against the model each cycle.
  always @(negedge clk) begin
    if (chk_en) begin
      int          a;
      int          w;
      int          q;
      int          cnt;
      logic [31:0] e_ru;
      bit          e_bz;
      bit          e_rdy;
      w = int'(bus.rd);
      for (int p = 0; p < NRP; p++) begin
        a = int'(bus.rs[p]);
        if (a == 0) e_ru = 32'd0;
        else if (bus.RuWr && w == a) e_ru = bus.RuWrData;
        else e_ru = m_regs[a];
        e_bz = (a != 0) && m_busy[a] && !(bus.RuWr && w == a);
        chk($sformatf("cyc ru[%0d] rs=%0d", p, a), 64'(bus.ru[p]), 64'(e_ru));
        chk($sformatf("cyc ru_busy[%0d] rs=%0d", p, a), 64'(bus.ru_busy[p]), 64'(e_bz));
      end
      q     = int'(bus.iss_rd);
      e_rdy = !m_busy[q] || (bus.RuWr && w == q);
      chk($sformatf("cyc iss_ready rd=%0d", q), 64'(bus.iss_ready), 64'(e_rdy));
      cnt = 0;
      for (int i = 0; i < NREGS; i++) cnt += int'(m_busy[i]);
      chk("cyc busy_cnt", 64'(bus.busy_cnt), 64'(cnt));
    end
  end

  task automatic idle();
    bus.RuWr      = 1'b0;
    bus.rd        = '0;
    bus.RuWrData  = '0;
    bus.iss_valid = 1'b0;
    bus.iss_rd    = '0;
    bus.rs        = '0;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    n_tests = 0;
    n_fail  = 0;
    chk_en  = 1'b0;
    rst     = 1'b1;
    idle();
    tick();
    tick();
    rst    = 1'b0;
    chk_en = 1'b1;

    // Reset values
    bus.rs[0] = 5'd2; bus.rs[1] = 5'd5; bus.iss_rd = 5'd13;
    @(negedge clk);
    chk("rst ru0 x2", 64'(bus.ru[0]), 64'd512);
    chk("rst ru1 x5", 64'(bus.ru[1]), 64'd0);
    chk("rst ru_busy", 64'(bus.ru_busy), 64'd0);
    chk("rst busy_cnt", 64'(bus.busy_cnt), 64'd0);
    chk("rst iss_ready", 64'(bus.iss_ready), 64'd1);
    tick();

    // x0 ignores writes, reservation of x0 is a no-op
    idle();
    bus.RuWr = 1'b1; bus.rd = 5'd0; bus.RuWrData = 32'hDEADBEEF;
    bus.iss_valid = 1'b1; bus.iss_rd = 5'd0;
    @(negedge clk);
    chk("x0 bypass ru0", 64'(bus.ru[0]), 64'd0);
    chk("x0 iss_ready", 64'(bus.iss_ready), 64'd1);
    tick();
    idle();
    @(negedge clk);
    chk("x0 read after write", 64'(bus.ru[0]), 64'd0);
    chk("x0 busy_cnt", 64'(bus.busy_cnt), 64'd0);
    tick();

    // Reserve x7, then write it with bypass
    idle(); bus.iss_valid = 1'b1; bus.iss_rd = 5'd7;
    tick();
    idle(); bus.iss_rd = 5'd7; bus.rs[0] = 5'd7;
    @(negedge clk);
    chk("x7 iss_ready busy", 64'(bus.iss_ready), 64'd0);
    chk("x7 ru_busy", 64'(bus.ru_busy[0]), 64'd1);
    chk("x7 busy_cnt", 64'(bus.busy_cnt), 64'd1);
    tick();
    bus.RuWr = 1'b1; bus.rd = 5'd7; bus.RuWrData = 32'h1234;
    @(negedge clk);
    chk("x7 bypass ru0", 64'(bus.ru[0]), 64'h1234);
    chk("x7 bypass ru_busy", 64'(bus.ru_busy[0]), 64'd0);
    chk("x7 ready on write", 64'(bus.iss_ready), 64'd1);
    tick();
    idle(); bus.rs[0] = 5'd7;
    @(negedge clk);
    chk("x7 busy_cnt after write", 64'(bus.busy_cnt), 64'd0);
    chk("x7 stored", 64'(bus.ru[0]), 64'h1234);
    tick();

    // Same-cycle write and reservation of busy x9
    idle(); bus.iss_valid = 1'b1; bus.iss_rd = 5'd9;
    tick();
    idle();
    bus.RuWr = 1'b1; bus.rd = 5'd9; bus.RuWrData = 32'hAA;
    bus.iss_valid = 1'b1; bus.iss_rd = 5'd9;
    @(negedge clk);
    chk("x9 ready via write", 64'(bus.iss_ready), 64'd1);
    tick();
    idle(); bus.rs[0] = 5'd9;
    @(negedge clk);
    chk("x9 data", 64'(bus.ru[0]), 64'hAA);
    chk("x9 still busy", 64'(bus.ru_busy[0]), 64'd1);
    chk("x9 busy_cnt", 64'(bus.busy_cnt), 64'd1);
    tick();
    bus.RuWr = 1'b1; bus.rd = 5'd9; bus.RuWrData = 32'h55;
    tick();

    // Mid-operation reset drops reservations and same-cycle traffic
    for (int i = 3; i <= 5; i++) begin
      idle(); bus.iss_valid = 1'b1; bus.iss_rd = 5'(i);
      tick();
    end
    idle();
    rst = 1'b1;
    bus.iss_valid = 1'b1; bus.iss_rd = 5'd6;
    bus.RuWr = 1'b1; bus.rd = 5'd2; bus.RuWrData = 32'h1;
    tick();
    rst = 1'b0;
    idle(); bus.rs[0] = 5'd3; bus.rs[1] = 5'd2; bus.iss_rd = 5'd3;
    @(negedge clk);
    chk("rst2 busy_cnt", 64'(bus.busy_cnt), 64'd0);
    chk("rst2 x3", 64'(bus.ru[0]), 64'd0);
    chk("rst2 x2", 64'(bus.ru[1]), 64'd512);
    chk("rst2 x3 ready", 64'(bus.iss_ready), 64'd1);
    tick();
    bus.rs[0] = 5'd4; bus.rs[1] = 5'd5; bus.iss_rd = 5'd6;
    @(negedge clk);
    chk("rst2 x4", 64'(bus.ru[0]), 64'd0);
    chk("rst2 x5", 64'(bus.ru[1]), 64'd0);
    chk("rst2 ru_busy", 64'(bus.ru_busy), 64'd0);
    chk("rst2 x6 ready", 64'(bus.iss_ready), 64'd1);
    tick();

    // Fill the scoreboard, then drain it in reverse order
    for (int i = 1; i < NREGS; i++) begin
      idle(); bus.iss_valid = 1'b1; bus.iss_rd = 5'(i);
      tick();
    end
    idle(); bus.iss_valid = 1'b1; bus.iss_rd = 5'd5;
    @(negedge clk);
    chk("full busy_cnt", 64'(bus.busy_cnt), 64'(NREGS - 1));
    chk("full x5 not ready", 64'(bus.iss_ready), 64'd0);
    tick();
    for (int i = NREGS - 1; i >= 1; i--) begin
      idle(); bus.RuWr = 1'b1; bus.rd = 5'(i); bus.RuWrData = 32'(i * 3);
      @(negedge clk);
      chk($sformatf("drain busy_cnt x%0d", i), 64'(bus.busy_cnt), 64'(i));
      tick();
    end
    idle();
    @(negedge clk);
    chk("drained busy_cnt", 64'(bus.busy_cnt), 64'd0);
    tick();

    // Randomized traffic against the model
    for (int n = 0; n < 3000; n++) begin
      rst           = ($urandom_range(0, 199) == 0);
      bus.RuWr      = $urandom_range(0, 2) == 0;
      bus.rd        = 5'($urandom_range(0, NREGS - 1));
      bus.RuWrData  = $urandom;
      bus.iss_valid = $urandom_range(0, 1) == 1;
      bus.iss_rd    = 5'($urandom_range(0, NREGS - 1));
      if ($urandom_range(0, 3) == 0) bus.iss_rd = bus.rd;
      bus.rs[0]     = 5'($urandom_range(0, NREGS - 1));
      bus.rs[1]     = ($urandom_range(0, 3) == 0) ? bus.rd : 5'($urandom_range(0, NREGS - 1));
      tick();
    end
    rst = 1'b0;
    idle();
    tick();

    chk_en = 1'b0;
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
